inst_dispatch: RTL and testbench
================================

Name: inst_dispatch

Overview:
- Downstream consumer of the instruction-fetch stage's 36-bit instruction stream (valid/ready).
- Buffers instructions in a 2-entry FIFO and decodes the 4-bit opcode.
- Issues the 32-bit payload to one of three engine command ports: load, compute, store.
- Implements SYNC (barrier on engine busy) and END (halt) control instructions, and reports status.

Parameters:
- IW, 36, instruction width; opcode = inst[IW-1:IW-4], payload = inst[IW-5:0].
- CW, 16, width of retired-instruction counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous assert, active-low
- instgen_s_data  input  IW  instruction from fetch stage
- instgen_s_valid  input  1  instruction valid
- instgen_s_ready  output  1  dispatcher can accept an instruction
- ld_m_data  output  IW-4  load-engine command payload
- ld_m_valid  output  1  load command valid
- ld_m_ready  input  1  load engine accepts
- cp_m_data  output  IW-4  compute command payload
- cp_m_valid  output  1  compute command valid
- cp_m_ready  input  1  compute engine accepts
- st_m_data  output  IW-4  store command payload
- st_m_valid  output  1  store command valid
- st_m_ready  input  1  store engine accepts
- ld_busy  input  1  load engine busy
- cp_busy  input  1  compute engine busy
- st_busy  input  1  store engine busy
- done  output  1  END retired; dispatcher halted
- err  output  1  sticky illegal-opcode flag
- inst_cnt  output  CW  retired-instruction count

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; state RUN.
  - done=0, err=0, inst_cnt=0; all *_m_valid=0.
  - instgen_s_ready=1 from the first cycle after reset.
- FIFO:
  - 2 entries; push on instgen_s_valid & instgen_s_ready.
  - instgen_s_ready = (count != 2); driven from registers only, no combinational path from any *_m_ready.
  - Simultaneous push and pop keeps count unchanged; order is strictly preserved.
- Latency: an instruction accepted in cycle N is at the FIFO head, and its command valid (if any) is asserted, in cycle N+1.
- Head processing happens only in state RUN with the FIFO non-empty. Opcodes:
  - 0 NOP: pop, retire.
  - 1 LOAD: ld_m_valid=1, ld_m_data=payload. Pop and retire on the ld_m_ready handshake; hold data stable while stalled.
  - 2 COMP: as LOAD, using the cp_* ports.
  - 3 STORE: as LOAD, using the st_* ports.
  - 4 SYNC: pop, retire, go to WAIT.
  - 5 END: pop, retire, go to HALT.
  - 6-15 illegal: pop, retire, err<=1 (sticky until reset).
- At most one *_m_valid is high in any cycle; *_m_data is don't-care while the matching valid is low.
- WAIT:
  - Issues nothing.
  - The first WAIT cycle is a guard cycle and is always spent in WAIT, so an engine's busy can rise after a command issued just before the SYNC.
  - From the second cycle onward: return to RUN on the first cycle with ld_busy|cp_busy|st_busy==0.
  - FIFO keeps accepting until full.
- HALT:
  - done=1; issues nothing.
  - FIFO fills to 2, then instgen_s_ready=0.
  - Exit only via reset.
- inst_cnt increments by 1 per retire and wraps modulo 2^CW.
- Reset mid-handshake: any pending command is dropped with no retire and its valid falls immediately; the engines must tolerate this.
- FSM: RUN→WAIT (SYNC), RUN→HALT (END), WAIT→RUN (guard elapsed and all idle). HALT is terminal.

Test Plan:
- Stream {LOAD 0x00000ABC, COMP 0x12345678, STORE 0x0000FFFF} with all *_m_ready=1 and busy=0:
  - ld/cp/st valid in consecutive cycles N+1..N+3 with matching payloads.
  - inst_cnt=3; err=0.
- LOAD with ld_m_ready=0 for 5 cycles and upstream valid held high:
  - ld_m_valid and data stable throughout.
  - FIFO fills and instgen_s_ready=0.
  - After ready=1, one accept per cycle resumes in order.
- COMP then SYNC, with cp_busy rising 1 cycle after issue and staying high 10 cycles:
  - The following LOAD is not issued until cp_busy has been 0 for one cycle; the guard cycle is observed.
- Opcode 0x9, then NOP:
  - err=1 and stays 1.
  - inst_cnt=2; no *_m_valid pulse.
- END, then 3 more LOADs offered:
  - done=1 one cycle after END reaches the head.
  - Exactly 2 further accepts, then instgen_s_ready=0; no issue.
  - rst_n pulse restores reset values.
- CW=4, 17 NOPs: inst_cnt wraps to 1.

Source files
------------

// File: rtl/inst_dispatch_if.sv
// Valid/ready stream bundle used for the fetch input and the three engine command ports.
// The master drives data/valid and the slave returns ready.
interface inst_dispatch_if #(
  parameter int W = 32
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/inst_dispatch.sv
// Instruction dispatcher: 2-entry FIFO after the fetch stage, opcode decode, and issue to
// load/compute/store engines, with SYNC barrier, END halt, illegal-opcode flag and retire count.
module inst_dispatch #(
  parameter int IW = 36,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  inst_dispatch_if.slave  instgen_s,
  inst_dispatch_if.master ld_m,
  inst_dispatch_if.master cp_m,
  inst_dispatch_if.master st_m,
  input  logic            ld_busy,
  input  logic            cp_busy,
  input  logic            st_busy,
  output logic            done,
  output logic            err,
  output logic [CW-1:0]   inst_cnt
);

  localparam int PW = IW - 4;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_COMP  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_SYNC  = 4'd4;
  localparam logic [3:0] OP_END   = 4'd5;

  // ST_GUARD is the first cycle after a SYNC, during which engine busy is ignored
  // so that a command issued just before the SYNC has time to raise its busy.
  typedef enum logic [1:0] {
    ST_RUN,
    ST_GUARD,
    ST_WAIT,
    ST_HALT
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [IW-1:0]   fifo_mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      fifo_cnt;

  logic            push;
  logic            pop;
  logic            err_set;
  logic            ld_valid;
  logic            cp_valid;
  logic            st_valid;
  logic [3:0]      opcode;
  logic [PW-1:0]   payload;
  logic            any_busy;

  assign instgen_s.ready = (fifo_cnt != 2'd2);
  assign push            = instgen_s.valid & instgen_s.ready;

  assign opcode  = fifo_mem[rd_ptr][IW-1:IW-4];
  assign payload = fifo_mem[rd_ptr][PW-1:0];

  assign ld_m.data  = payload;
  assign cp_m.data  = payload;
  assign st_m.data  = payload;
  assign ld_m.valid = ld_valid;
  assign cp_m.valid = cp_valid;
  assign st_m.valid = st_valid;

  assign any_busy = ld_busy | cp_busy | st_busy;
  assign done     = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= instgen_s.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      err      <= 1'b0;
      inst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (err_set) begin
        err <= 1'b1;
      end
      if (pop) begin
        inst_cnt <= inst_cnt + CW'(1);
      end
    end
  end

  // Every pop is a retire; engine commands pop only on their handshake.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    err_set   = 1'b0;
    ld_valid  = 1'b0;
    cp_valid  = 1'b0;
    st_valid  = 1'b0;
    case (state)
      ST_RUN: begin
        if (fifo_cnt != 2'd0) begin
          case (opcode)
            OP_NOP: begin
              pop = 1'b1;
            end
            OP_LOAD: begin
              ld_valid = 1'b1;
              pop      = ld_m.ready;
            end
            OP_COMP: begin
              cp_valid = 1'b1;
              pop      = cp_m.ready;
            end
            OP_STORE: begin
              st_valid = 1'b1;
              pop      = st_m.ready;
            end
            OP_SYNC: begin
              pop       = 1'b1;
              state_nxt = ST_GUARD;
            end
            OP_END: begin
              pop       = 1'b1;
              state_nxt = ST_HALT;
            end
            default: begin
              pop     = 1'b1;
              err_set = 1'b1;
            end
          endcase
        end
      end
      ST_GUARD: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!any_busy) begin
          state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_dispatch.sv
// Directed bench for inst_dispatch: each task drives one scenario cycle by cycle and checks
// against hand-computed expectations; a second instance with CW=4 covers counter wrap.
module tb_inst_dispatch;

  localparam int IW = 36;
  localparam int PW = 32;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_COMP  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_SYNC  = 4'd4;
  localparam logic [3:0] OP_END   = 4'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_busy, cp_busy, st_busy;
  logic        done, err;
  logic [15:0] inst_cnt;
  logic        done4, err4;
  logic [3:0]  inst_cnt4;

  int errors = 0;
  int checks = 0;

  inst_dispatch_if #(.W(IW)) instgen ();
  inst_dispatch_if #(.W(PW)) ld_if ();
  inst_dispatch_if #(.W(PW)) cp_if ();
  inst_dispatch_if #(.W(PW)) st_if ();
  inst_dispatch_if #(.W(IW)) instgen4 ();
  inst_dispatch_if #(.W(PW)) ld4 ();
  inst_dispatch_if #(.W(PW)) cp4 ();
  inst_dispatch_if #(.W(PW)) st4 ();

  inst_dispatch #(.IW(IW), .CW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instgen_s (instgen),
    .ld_m      (ld_if),
    .cp_m      (cp_if),
    .st_m      (st_if),
    .ld_busy   (ld_busy),
    .cp_busy   (cp_busy),
    .st_busy   (st_busy),
    .done      (done),
    .err       (err),
    .inst_cnt  (inst_cnt)
  );

  inst_dispatch #(.IW(IW), .CW(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .instgen_s (instgen4),
    .ld_m      (ld4),
    .cp_m      (cp4),
    .st_m      (st4),
    .ld_busy   (1'b0),
    .cp_busy   (1'b0),
    .st_busy   (1'b0),
    .done      (done4),
    .err       (err4),
    .inst_cnt  (inst_cnt4)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [PW-1:0] p);
    return {op, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    instgen.valid  = 1'b0;
    instgen.data   = '0;
    instgen4.valid = 1'b0;
    instgen4.data  = '0;
    ld_if.ready    = 1'b0;
    cp_if.ready    = 1'b0;
    st_if.ready    = 1'b0;
    ld4.ready      = 1'b1;
    cp4.ready      = 1'b1;
    st4.ready      = 1'b1;
    ld_busy        = 1'b0;
    cp_busy        = 1'b0;
    st_busy        = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if ({ld_if.valid, cp_if.valid, st_if.valid} !== 3'b000) begin errors++; $display("[TB] FAIL reset_valids: got %b expected 000", {ld_if.valid, cp_if.valid, st_if.valid}); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    checks++; if (inst_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", inst_cnt); end
    checks++; if (instgen.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", instgen.ready); end
    checks++; if (inst_cnt4 !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt4: got %0d expected 0", inst_cnt4); end
    tick();
  endtask

  task automatic test_stream();
    logic [PW-1:0] pay [3];
    logic [2:0]    exp_v;
    logic [PW-1:0] got;
    pay = '{32'h00000ABC, 32'h12345678, 32'h0000FFFF};
    do_reset();
    ld_if.ready = 1'b1; cp_if.ready = 1'b1; st_if.ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      instgen.valid = (k < 3);
      case (k)
        0: instgen.data = mk(OP_LOAD,  pay[0]);
        1: instgen.data = mk(OP_COMP,  pay[1]);
        2: instgen.data = mk(OP_STORE, pay[2]);
        default: instgen.data = '0;
      endcase
      #1;
      exp_v = (k >= 1 && k <= 3) ? (3'b001 << (k - 1)) : 3'b000;
      checks++; if ({st_if.valid, cp_if.valid, ld_if.valid} !== exp_v) begin errors++; $display("[TB] FAIL stream_valids k=%0d: got %b expected %b", k, {st_if.valid, cp_if.valid, ld_if.valid}, exp_v); end
      if (k >= 1 && k <= 3) begin
        got = (k == 1) ? ld_if.data : (k == 2) ? cp_if.data : st_if.data;
        checks++; if (got !== pay[k-1]) begin errors++; $display("[TB] FAIL stream_data k=%0d: got %h expected %h", k, got, pay[k-1]); end
      end
      tick();
    end
    #1;
    checks++; if (inst_cnt !== 16'd3) begin errors++; $display("[TB] FAIL stream_cnt: got %0d expected 3", inst_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL stream_err: got %b expected 0", err); end
  endtask

  task automatic test_stall();
    logic [PW-1:0] pay [4];
    int            exp_idx [10];
    logic          exp_rdy [10];
    int            idx;
    logic          acc;
    pay     = '{32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
    exp_idx = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3};
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    idx = 0;
    for (int k = 0; k <= 10; k++) begin
      instgen.valid = (idx < 4);
      instgen.data  = (idx < 4) ? mk(OP_LOAD, pay[idx]) : '0;
      ld_if.ready   = (k >= 6);
      #1;
      if (k <= 9) begin
        checks++; if (instgen.ready !== exp_rdy[k]) begin errors++; $display("[TB] FAIL stall_ready k=%0d: got %b expected %b", k, instgen.ready, exp_rdy[k]); end
      end
      if (k >= 1 && k <= 9) begin
        checks++; if (ld_if.valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid k=%0d: got %b expected 1", k, ld_if.valid); end
        checks++; if (ld_if.data !== pay[exp_idx[k]]) begin errors++; $display("[TB] FAIL stall_data k=%0d: got %h expected %h", k, ld_if.data, pay[exp_idx[k]]); end
      end
      if (k == 10) begin
        checks++; if (ld_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_idle: got %b expected 0", ld_if.valid); end
        checks++; if (inst_cnt !== 16'd4) begin errors++; $display("[TB] FAIL stall_cnt: got %0d expected 4", inst_cnt); end
      end
      acc = instgen.valid & instgen.ready;
      tick();
      if (acc) idx++;
    end
  endtask

  task automatic test_sync();
    logic [IW-1:0] prog [3];
    int            idx;
    logic          acc;
    prog = '{mk(OP_COMP, 32'h00001111), mk(OP_SYNC, 32'h0), mk(OP_LOAD, 32'h00002222)};
    // Busy rises the cycle after the COMP handshake and holds for 10 cycles.
    do_reset();
    ld_if.ready = 1'b1; cp_if.ready = 1'b1; st_if.ready = 1'b1;
    idx = 0;
    for (int k = 0; k <= 14; k++) begin
      instgen.valid = (idx < 3);
      instgen.data  = (idx < 3) ? prog[idx] : '0;
      cp_busy       = (k >= 2 && k <= 11);
      #1;
      checks++; if (cp_if.valid !== (k == 1)) begin errors++; $display("[TB] FAIL sync_cp_valid k=%0d: got %b expected %b", k, cp_if.valid, (k == 1)); end
      checks++; if (ld_if.valid !== (k == 13)) begin errors++; $display("[TB] FAIL sync_ld_valid k=%0d: got %b expected %b", k, ld_if.valid, (k == 13)); end
      if (k == 13) begin
        checks++; if (ld_if.data !== 32'h00002222) begin errors++; $display("[TB] FAIL sync_ld_data: got %h expected 00002222", ld_if.data); end
      end
      acc = instgen.valid & instgen.ready;
      tick();
      if (acc) idx++;
    end
    #1;
    checks++; if (inst_cnt !== 16'd3) begin errors++; $display("[TB] FAIL sync_cnt: got %0d expected 3", inst_cnt); end
    // With engines idle the guard cycle alone delays the LOAD to cycle 5.
    do_reset();
    ld_if.ready = 1'b1; cp_if.ready = 1'b1; st_if.ready = 1'b1;
    idx = 0;
    for (int k = 0; k <= 6; k++) begin
      instgen.valid = (idx < 3);
      instgen.data  = (idx < 3) ? prog[idx] : '0;
      #1;
      checks++; if (ld_if.valid !== (k == 5)) begin errors++; $display("[TB] FAIL guard_ld_valid k=%0d: got %b expected %b", k, ld_if.valid, (k == 5)); end
      acc = instgen.valid & instgen.ready;
      tick();
      if (acc) idx++;
    end
  endtask

  task automatic test_illegal();
    do_reset();
    ld_if.ready = 1'b1; cp_if.ready = 1'b1; st_if.ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      instgen.valid = (k < 2);
      instgen.data  = (k == 0) ? mk(4'h9, 32'h0000DEAD) : mk(OP_NOP, 32'h0);
      #1;
      checks++; if ({ld_if.valid, cp_if.valid, st_if.valid} !== 3'b000) begin errors++; $display("[TB] FAIL illegal_valids k=%0d: got %b expected 000", k, {ld_if.valid, cp_if.valid, st_if.valid}); end
      checks++; if (err !== (k >= 2)) begin errors++; $display("[TB] FAIL illegal_err k=%0d: got %b expected %b", k, err, (k >= 2)); end
      tick();
    end
    #1;
    checks++; if (inst_cnt !== 16'd2) begin errors++; $display("[TB] FAIL illegal_cnt: got %0d expected 2", inst_cnt); end
  endtask

  task automatic test_end();
    logic [IW-1:0] prog [4];
    int            idx;
    logic          acc;
    prog = '{mk(OP_END, 32'h0), mk(OP_LOAD, 32'h00000001), mk(OP_LOAD, 32'h00000002), mk(OP_LOAD, 32'h00000003)};
    do_reset();
    ld_if.ready = 1'b1; cp_if.ready = 1'b1; st_if.ready = 1'b1;
    idx = 0;
    for (int k = 0; k <= 7; k++) begin
      instgen.valid = (idx < 4);
      instgen.data  = (idx < 4) ? prog[idx] : '0;
      #1;
      checks++; if (done !== (k >= 2)) begin errors++; $display("[TB] FAIL end_done k=%0d: got %b expected %b", k, done, (k >= 2)); end
      checks++; if (ld_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL end_no_issue k=%0d: got %b expected 0", k, ld_if.valid); end
      acc = instgen.valid & instgen.ready;
      tick();
      if (acc) idx++;
    end
    #1;
    checks++; if (idx !== 3) begin errors++; $display("[TB] FAIL end_accepts: got %0d expected 3 (END plus 2 loads)", idx); end
    checks++; if (instgen.ready !== 1'b0) begin errors++; $display("[TB] FAIL end_ready: got %b expected 0", instgen.ready); end
    checks++; if (inst_cnt !== 16'd1) begin errors++; $display("[TB] FAIL end_cnt: got %0d expected 1", inst_cnt); end
    instgen.valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL end_rst_done: got %b expected 0", done); end
    checks++; if (instgen.ready !== 1'b1) begin errors++; $display("[TB] FAIL end_rst_ready: got %b expected 1", instgen.ready); end
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL end_post_done: got %b expected 0", done); end
    checks++; if (ld_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL end_post_valid: got %b expected 0", ld_if.valid); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    instgen.valid = 1'b1;
    instgen.data  = mk(OP_LOAD, 32'h0BADF00D);
    tick();
    instgen.valid = 1'b0;
    #1;
    checks++; if (ld_if.valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pending: got %b expected 1", ld_if.valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (ld_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_drop: got %b expected 0", ld_if.valid); end
    checks++; if (inst_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_cnt: got %0d expected 0", inst_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k <= 18; k++) begin
      instgen4.valid = (k < 17);
      instgen4.data  = mk(OP_NOP, 32'h0);
      #1;
      if (k == 16) begin
        checks++; if (inst_cnt4 !== 4'd15) begin errors++; $display("[TB] FAIL wrap_cnt15: got %0d expected 15", inst_cnt4); end
      end
      if (k == 17) begin
        checks++; if (inst_cnt4 !== 4'd0) begin errors++; $display("[TB] FAIL wrap_cnt0: got %0d expected 0", inst_cnt4); end
      end
      if (k == 18) begin
        checks++; if (inst_cnt4 !== 4'd1) begin errors++; $display("[TB] FAIL wrap_cnt1: got %0d expected 1", inst_cnt4); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_sync();
    test_illegal();
    test_end();
    test_reset_midflight();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
